// File: rtl/mux_rr_arbiter_pkg.sv
// Shared definitions for the round-robin mux arbiter: state encoding,
// requester count and the index-to-one-hot helper.
package mux_rr_arbiter_pkg;

  localparam int NREQ = 4;

  localparam logic IDLE  = 1'b0;
  localparam logic GRANT = 1'b1;

  function automatic logic [NREQ-1:0] idx_to_onehot(input logic [1:0] idx);
    logic [NREQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_mux.sv
// Shared 4:1 single-bit datapath mux; the arbiter is its only select source.
module Mux4_1 (
  input  logic [3:0] w,
  input  logic [1:0] s,
  output logic       y
);

  assign y = w[s];

endmodule

// File: rtl/mux_rr_arbiter_pick.sv
// Combinational round-robin picker: finds the first set request starting
// at ptr and wrapping around modulo 4.
module rr_pick4
  import mux_rr_arbiter_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      ptr,
  output logic [1:0]      idx,
  output logic            any
);

  logic [1:0] cand;

  // Scan from the lowest priority back to ptr so the last hit is the winner.
  always_comb begin
    idx  = ptr;
    any  = 1'b0;
    cand = ptr;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = ptr + 2'(i);
      if (req[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter and sequencer for the shared 4:1 mux. Grants one
// requester at a time, limits hold time to MAX_HOLD cycles, forces an idle
// cycle between owners and registers the selected data bit.
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CW       = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            done,
  input  logic [NREQ-1:0] w,
  output logic [NREQ-1:0] gnt,
  output logic [1:0]      s,
  output logic            busy,
  output logic            timeout,
  output logic            y
);

  logic          state;
  logic [1:0]    ptr;
  logic [CW-1:0] hold_cnt;
  logic [1:0]    pick_idx;
  logic          pick_any;
  logic          mux_y;
  logic          at_limit;
  logic          release_now;
  logic          timeout_cause;

  rr_pick4 u_pick (
    .req (req),
    .ptr (ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  Mux4_1 u_mux (
    .w (w),
    .s (s),
    .y (mux_y)
  );

  // s always names the current owner while granted, so it indexes req directly.
  assign at_limit      = (hold_cnt == CW'(MAX_HOLD - 1));
  assign release_now   = done | ~req[s] | at_limit;
  assign timeout_cause = at_limit & ~done & req[s];

  // Grant/release sequencing, hold counting and the registered mux output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      s        <= 2'd0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      y        <= 1'b0;
      ptr      <= 2'd0;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          timeout <= 1'b0;
          y       <= 1'b0;
          if (pick_any) begin
            state    <= GRANT;
            gnt      <= idx_to_onehot(pick_idx);
            s        <= pick_idx;
            busy     <= 1'b1;
            hold_cnt <= '0;
          end
        end
        GRANT: begin
          y        <= mux_y;
          hold_cnt <= hold_cnt + CW'(1);
          if (release_now) begin
            state   <= IDLE;
            gnt     <= '0;
            busy    <= 1'b0;
            ptr     <= s + 2'd1;
            timeout <= timeout_cause;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: directed scenarios followed by
// randomized traffic compared against a cycle-level ownership model.
module tb_mux_rr_arbiter;

  localparam int MAX_HOLD = 8;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] w;
  logic [3:0] gnt;
  logic [1:0] s;
  logic       busy;
  logic       timeout;
  logic       y;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the mux, for how many cycles, and whose turn is next.
  int   m_owner;
  int   m_ptr;
  int   m_held;
  int   m_sel;
  bit   m_timeout;
  bit   m_y;

  mux_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CW(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .w       (w),
    .gnt     (gnt),
    .s       (s),
    .busy    (busy),
    .timeout (timeout),
    .y       (y)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_owner   = -1;
    m_ptr     = 0;
    m_held    = 0;
    m_sel     = 0;
    m_timeout = 1'b0;
    m_y       = 1'b0;
  endtask

  // One clock edge of arbitration described in terms of owners and turns.
  task automatic modelStep(input logic [3:0] r, input logic d, input logic [3:0] wv);
    if (m_owner < 0) begin
      m_timeout = 1'b0;
      m_y       = 1'b0;
      for (int n = 0; n < 4; n++) begin
        int k;
        k = (m_ptr + n) % 4;
        if (r[k] && m_owner < 0) begin
          m_owner = k;
          m_sel   = k;
          m_held  = 1;
        end
      end
    end else begin
      m_y = wv[m_owner];
      if (d || !r[m_owner] || m_held == MAX_HOLD) begin
        m_timeout = (m_held == MAX_HOLD) && !d && r[m_owner];
        m_ptr     = (m_owner + 1) % 4;
        m_owner   = -1;
      end else begin
        m_held++;
      end
    end
  endtask

  task automatic compareAll(input string tag);
    logic [3:0] exp_gnt;
    exp_gnt = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    checkOutput({tag, "_gnt"},     32'(gnt),     32'(exp_gnt));
    checkOutput({tag, "_s"},       32'(s),       32'(m_sel));
    checkOutput({tag, "_busy"},    32'(busy),    32'(m_owner >= 0));
    checkOutput({tag, "_timeout"}, 32'(timeout), 32'(m_timeout));
    checkOutput({tag, "_y"},       32'(y),       32'(m_y));
  endtask

  task automatic applyStimulus(input string tag, input logic [3:0] r, input logic d, input logic [3:0] wv);
    req  = r;
    done = d;
    w    = wv;
    @(posedge clk);
    modelStep(r, d, wv);
    #1;
    compareAll(tag);
  endtask

  // Asynchronous reset taken mid-cycle; outputs must clear without waiting for a clock.
  task automatic pulseReset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    checkOutput({tag, "_rst_gnt"},     32'(gnt),     32'd0);
    checkOutput({tag, "_rst_y"},       32'(y),       32'd0);
    checkOutput({tag, "_rst_timeout"}, 32'(timeout), 32'd0);
    checkOutput({tag, "_rst_busy"},    32'(busy),    32'd0);
    checkOutput({tag, "_rst_s"},       32'(s),       32'd0);
    modelReset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] rot_exp [8];
    logic [3:0] rnd_req;
    rot_exp = '{4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};

    rst  = 1'b1;
    req  = 4'b1111;
    done = 1'b0;
    w    = 4'b0000;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_gnt",  32'(gnt),  32'd0);
    checkOutput("reset_s",    32'(s),    32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_y",    32'(y),    32'd0);
    rst = 1'b0;

    applyStimulus("first", 4'b1111, 1'b0, 4'b0000);
    checkOutput("first_gnt_const", 32'(gnt), 32'b0001);
    checkOutput("first_s_const",   32'(s),   32'd0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus("rot", 4'b1111, (i % 2 == 0), 4'b0000);
      checkOutput("rot_gnt_const", 32'(gnt), 32'(rot_exp[i]));
    end

    applyStimulus("skip_rel", 4'b1001, 1'b1, 4'b0000);
    applyStimulus("skip", 4'b1001, 1'b0, 4'b0000);
    checkOutput("skip_gnt_const", 32'(gnt), 32'b1000);
    checkOutput("skip_s_const",   32'(s),   32'd3);

    applyStimulus("to_rel", 4'b1001, 1'b1, 4'b0000);
    applyStimulus("to_grant", 4'b0100, 1'b0, 4'b0000);
    checkOutput("to_gnt_const", 32'(gnt), 32'b0100);
    for (int i = 0; i < MAX_HOLD - 1; i++) begin
      applyStimulus("to_hold", 4'b0100, 1'b0, 4'b0000);
      checkOutput("to_hold_const", 32'(gnt), 32'b0100);
    end
    applyStimulus("to_fire", 4'b0100, 1'b0, 4'b0000);
    checkOutput("to_fire_gnt_const",     32'(gnt),     32'b0000);
    checkOutput("to_fire_timeout_const", 32'(timeout), 32'd1);
    applyStimulus("to_regrant", 4'b0100, 1'b0, 4'b0000);
    checkOutput("to_regrant_gnt_const",     32'(gnt),     32'b0100);
    checkOutput("to_regrant_timeout_const", 32'(timeout), 32'd0);

    for (int i = 0; i < MAX_HOLD - 1; i++) begin
      applyStimulus("coin_hold", 4'b0100, 1'b0, 4'b0000);
    end
    applyStimulus("coin_rel", 4'b0100, 1'b1, 4'b0000);
    checkOutput("coin_gnt_const",     32'(gnt),     32'b0000);
    checkOutput("coin_timeout_const", 32'(timeout), 32'd0);

    applyStimulus("dp_grant", 4'b0100, 1'b0, 4'b0100);
    checkOutput("dp_s_const", 32'(s), 32'd2);
    applyStimulus("dp_data", 4'b0100, 1'b0, 4'b0100);
    checkOutput("dp_y_const", 32'(y), 32'd1);
    pulseReset("dp");

    rnd_req = 4'b0000;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) rnd_req = 4'($urandom_range(0, 15));
      applyStimulus("rnd", rnd_req, ($urandom_range(0, 11) == 0), 4'($urandom_range(0, 15)));
      if (busy && $urandom_range(0, 199) == 0) pulseReset("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
